// File: rtl/vec_engine_pipe.sv
// Pipelined element-wise vector ALU between the NPU command sequencer and the scratchpad SRAM.
// Issues one read pair and retires one write per cycle through a read -> compute -> write pipe.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_RUN   | issuing one read per cycle, idx = 0..length-1
// S_DRAIN | last two results retiring
// S_DONE  | one-cycle done pulse
module vec_engine_pipe #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16,
    parameter int MUL_SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        opcode,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W-1:0] src0_base,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [7:0]        scale,
    input  logic [4:0]        shift,
    input  logic [DATA_W-1:0] clamp_lo,
    input  logic [DATA_W-1:0] clamp_hi,
    input  logic              abort,
    output logic              sram_rd0_en,
    output logic [ADDR_W-1:0] sram_rd0_addr,
    input  logic [DATA_W-1:0] sram_rd0_data,
    output logic              sram_rd1_en,
    output logic [ADDR_W-1:0] sram_rd1_addr,
    input  logic [DATA_W-1:0] sram_rd1_data,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_SCL  = 3'd3;
    localparam logic [2:0] OP_CLP  = 3'd4;
    localparam logic [2:0] OP_RELU = 3'd5;
    localparam logic [2:0] OP_MAX  = 3'd6;
    localparam logic [2:0] OP_MIN  = 3'd7;

    // Wide enough for scale products plus a rounding term of up to 2^30.
    localparam int XW = 2*DATA_W + 41;
    localparam logic signed [XW-1:0] X_MAX = (XW'(1) <<< (DATA_W-1)) - XW'(1);
    localparam logic signed [XW-1:0] X_MIN = -(XW'(1) <<< (DATA_W-1));
    localparam logic signed [2*DATA_W-1:0] MUL_RND = (2*DATA_W)'(1) <<< (MUL_SHIFT-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    r_state;
    logic [2:0]                r_op;
    logic [LEN_W-1:0]          r_idx;
    logic [LEN_W-1:0]          r_rem;
    logic                      r_drain;
    logic [ADDR_W-1:0]         r_src0;
    logic [ADDR_W-1:0]         r_src1;
    logic [ADDR_W-1:0]         r_dst;
    logic [7:0]                r_scale;
    logic [4:0]                r_shift;
    logic signed [DATA_W-1:0]  r_lo;
    logic signed [DATA_W-1:0]  r_hi;

    logic                      r_p1_valid;
    logic [LEN_W-1:0]          r_p1_idx;
    logic                      r_p2_valid;
    logic [ADDR_W-1:0]         r_p2_addr;
    logic [DATA_W-1:0]         r_p2_data;

    logic                      w_kill;
    logic                      w_issue;
    logic                      w_use_b;
    logic signed [DATA_W-1:0]  w_a;
    logic signed [DATA_W-1:0]  w_b;
    logic signed [DATA_W:0]    w_add;
    logic signed [DATA_W:0]    w_sub;
    logic signed [2*DATA_W-1:0] w_mul;
    logic signed [2*DATA_W-1:0] w_mul_q;
    logic signed [XW-1:0]      w_p;
    logic signed [XW-1:0]      w_rnd;
    logic signed [XW-1:0]      w_sc;
    logic signed [DATA_W-1:0]  w_min_hi;
    logic signed [DATA_W-1:0]  w_clamp;
    logic signed [XW-1:0]      w_wide;
    logic [DATA_W-1:0]         w_res;

    assign w_kill  = abort & ((r_state == S_RUN) | (r_state == S_DRAIN));
    assign w_issue = (r_state == S_RUN) & ~w_kill;
    assign w_use_b = (r_op == OP_ADD) | (r_op == OP_SUB) | (r_op == OP_MUL) |
                     (r_op == OP_MAX) | (r_op == OP_MIN);

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign sram_rd0_en   = w_issue;
    assign sram_rd1_en   = w_issue & w_use_b;
    assign sram_rd0_addr = r_src0 + ADDR_W'(r_idx);
    assign sram_rd1_addr = r_src1 + ADDR_W'(r_idx);
    assign sram_wr_en    = r_p2_valid & ~w_kill;
    assign sram_wr_addr  = r_p2_addr;
    assign sram_wr_data  = r_p2_data;

    assign w_a      = sram_rd0_data;
    assign w_b      = sram_rd1_data;
    assign w_add    = signed'({w_a[DATA_W-1], w_a}) + signed'({w_b[DATA_W-1], w_b});
    assign w_sub    = signed'({w_a[DATA_W-1], w_a}) - signed'({w_b[DATA_W-1], w_b});
    assign w_mul    = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);
    assign w_mul_q  = (w_mul + MUL_RND) >>> MUL_SHIFT;
    assign w_p      = XW'(w_a) * XW'(signed'({1'b0, r_scale}));
    assign w_rnd    = (r_shift == 5'd0) ? '0 : (XW'(1) <<< (r_shift - 5'd1));
    assign w_sc     = (w_p + w_rnd) >>> r_shift;
    // Applying the upper bound first makes lo win whenever lo > hi.
    assign w_min_hi = (w_a > r_hi) ? r_hi : w_a;
    assign w_clamp  = (w_min_hi < r_lo) ? r_lo : w_min_hi;

    always_comb begin
        w_wide = '0;
        case (r_op)
            OP_ADD:  w_wide = XW'(w_add);
            OP_SUB:  w_wide = XW'(w_sub);
            OP_MUL:  w_wide = XW'(w_mul_q);
            OP_SCL:  w_wide = w_sc;
            OP_CLP:  w_wide = XW'(w_clamp);
            OP_RELU: w_wide = w_a[DATA_W-1] ? '0 : XW'(w_a);
            OP_MAX:  w_wide = (w_a > w_b) ? XW'(w_a) : XW'(w_b);
            OP_MIN:  w_wide = (w_a < w_b) ? XW'(w_a) : XW'(w_b);
            default: w_wide = '0;
        endcase
    end

    assign w_res = (w_wide > X_MAX) ? DATA_W'(X_MAX) :
                   (w_wide < X_MIN) ? DATA_W'(X_MIN) : w_wide[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_drain <= 1'b0;
            r_src0  <= '0;
            r_src1  <= '0;
            r_dst   <= '0;
            r_scale <= '0;
            r_shift <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= opcode;
                        r_idx   <= '0;
                        r_rem   <= length;
                        r_src0  <= src0_base;
                        r_src1  <= src1_base;
                        r_dst   <= dst_base;
                        r_scale <= scale;
                        r_shift <= shift;
                        r_lo    <= clamp_lo;
                        r_hi    <= clamp_hi;
                        r_state <= (length == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + LEN_W'(1);
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_drain <= 1'b1;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_kill) begin
                        r_state <= S_IDLE;
                    end else if (!r_drain) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid <= 1'b0;
            r_p1_idx   <= '0;
            r_p2_valid <= 1'b0;
            r_p2_addr  <= '0;
            r_p2_data  <= '0;
        end else begin
            r_p1_valid <= w_issue;
            r_p1_idx   <= r_idx;
            r_p2_valid <= r_p1_valid & ~w_kill;
            r_p2_addr  <= r_dst + ADDR_W'(r_p1_idx);
            r_p2_data  <= w_res;
        end
    end

endmodule

// File: tb/tb_vec_engine_pipe.sv
// Directed bench for vec_engine_pipe: SRAM model, per-command cycle monitor, hand-computed results.
module tb_vec_engine_pipe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_SCL  = 3'd3;
    localparam logic [2:0] OP_CLP  = 3'd4;
    localparam logic [2:0] OP_RELU = 3'd5;
    localparam logic [2:0] OP_MAX  = 3'd6;
    localparam logic [2:0] OP_MIN  = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    opcode = '0;
    logic [LW-1:0] length = '0;
    logic [AW-1:0] src0_base = '0;
    logic [AW-1:0] src1_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [7:0]    scale = '0;
    logic [4:0]    shift = '0;
    logic [DW-1:0] clamp_lo = '0;
    logic [DW-1:0] clamp_hi = '0;
    logic          abort = 1'b0;
    logic          rd0_en, rd1_en, wr_en;
    logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
    logic [DW-1:0] rd0_data = '0;
    logic [DW-1:0] rd1_data = '0;
    logic [DW-1:0] wr_data;
    logic          busy, done;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];

    vec_engine_pipe #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .MUL_SHIFT(7)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .opcode(opcode), .length(length), .src0_base(src0_base), .src1_base(src1_base),
        .dst_base(dst_base), .scale(scale), .shift(shift), .clamp_lo(clamp_lo),
        .clamp_hi(clamp_hi), .abort(abort),
        .sram_rd0_en(rd0_en), .sram_rd0_addr(rd0_addr), .sram_rd0_data(rd0_data),
        .sram_rd1_en(rd1_en), .sram_rd1_addr(rd1_addr), .sram_rd1_data(rd1_data),
        .sram_wr_en(wr_en), .sram_wr_addr(wr_addr), .sram_wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd0_en) rd0_data <= mem0[rd0_addr];
        if (rd1_en) rd1_data <= mem1[rd1_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int exp_d[$];
    int n_rd0, n_rd1, n_busy, n_done, done_cyc, rd_bad, wr_after_rst;
    logic [5:0] rst_vec;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic setm(input logic [15:0] addr, input int a, input int b);
        mem0[addr] = 8'(a);
        mem1[addr] = 8'(b);
    endtask

    // Cycle k counts from the accept edge: cycle 1 is the first cycle after acceptance.
    task automatic run_cmd(input logic [2:0] op, input int len, input logic [15:0] s0,
                           input logic [15:0] s1, input logic [15:0] d, input int sc,
                           input int sh, input int lo, input int hi,
                           input int abort_at, input int rst_at, input int spam_at);
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        n_rd0 = 0; n_rd1 = 0; n_busy = 0; n_done = 0; done_cyc = -1;
        rd_bad = 0; wr_after_rst = 0; rst_vec = '1;
        @(negedge clk);
        cmd_valid = 1'b1; opcode = op; length = LW'(len);
        src0_base = s0; src1_base = s1; dst_base = d;
        scale = 8'(sc); shift = 5'(sh); clamp_lo = 8'(lo); clamp_hi = 8'(hi);
        @(posedge clk);
        for (int k = 1; k <= len + 8; k++) begin
            @(negedge clk);
            cmd_valid = (spam_at > 0) && (k >= spam_at) && (k < spam_at + 4);
            opcode = 3'($urandom); length = LW'($urandom);
            src0_base = AW'($urandom); src1_base = AW'($urandom); dst_base = AW'($urandom);
            scale = 8'($urandom); shift = 5'($urandom);
            clamp_lo = 8'($urandom); clamp_hi = 8'($urandom);
            abort = (k == abort_at);
            if (k == rst_at) rst_n = 1'b0;
            if (k == rst_at + 2) rst_n = 1'b1;
            #1;
            if (k == rst_at) rst_vec = {cmd_ready, busy, done, rd0_en, rd1_en, wr_en};
            if (busy) n_busy++;
            if (done) begin n_done++; done_cyc = k; end
            if (rd0_en) begin
                if (rd0_addr != s0 + 16'(n_rd0)) rd_bad++;
                n_rd0++;
            end
            if (rd1_en) begin
                if (rd1_addr != s1 + 16'(n_rd1)) rd_bad++;
                n_rd1++;
            end
            if (wr_en) begin
                wq_addr.push_back(int'(wr_addr));
                wq_data.push_back(int'($signed(wr_data)));
                wq_cyc.push_back(k);
                if (rst_at > 0 && k >= rst_at) wr_after_rst++;
            end
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input logic [15:0] d);
        logic [15:0] ea;
        chk($sformatf("%s_nwr", tag), wq_data.size(), exp_d.size());
        foreach (exp_d[i]) begin
            if (i < wq_data.size()) begin
                ea = d + 16'(i);
                chk($sformatf("%s_data%0d", tag, i), wq_data[i], exp_d[i]);
                chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], int'(ea));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outs", {cmd_ready, busy, done, rd0_en, rd1_en, wr_en}, 6'b100000);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) setm(16'h0100 + 16'(i), 100, 50);
        run_cmd(OP_ADD, 4, 16'h0100, 16'h0100, 16'h0300, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{127, 127, 127, 127};
        chk_writes("add", 16'h0300);
        chk("add_first_wr_cyc", wq_cyc[0], 3);
        chk("add_done_cyc", done_cyc, 7);
        chk("add_busy", n_busy, 7);

        setm(16'h0110, -100, 100); setm(16'h0111, -100, 100);
        run_cmd(OP_SUB, 2, 16'h0110, 16'h0110, 16'h0310, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{-128, -128};
        chk_writes("sub", 16'h0310);

        setm(16'h0120, 64, 64); setm(16'h0121, -128, -128);
        run_cmd(OP_MUL, 2, 16'h0120, 16'h0120, 16'h0320, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{32, 127};
        chk_writes("mul", 16'h0320);

        setm(16'h0130, -3, 0);
        run_cmd(OP_SCL, 1, 16'h0130, 16'h0130, 16'h0330, 3, 1, 0, 0, 0, 0, 0);
        exp_d = '{-4};
        chk_writes("scl_sh1", 16'h0330);
        chk("scl_rd1_cnt", n_rd1, 0);
        run_cmd(OP_SCL, 1, 16'h0130, 16'h0130, 16'h0330, 3, 0, 0, 0, 0, 0, 0);
        exp_d = '{-9};
        chk_writes("scl_sh0", 16'h0330);

        setm(16'h0140, -50, 0); setm(16'h0141, 5, 0); setm(16'h0142, 90, 0);
        run_cmd(OP_CLP, 3, 16'h0140, 16'h0140, 16'h0340, 0, 0, -10, 20, 0, 0, 0);
        exp_d = '{-10, 5, 20};
        chk_writes("clamp", 16'h0340);
        chk("clamp_rd1_cnt", n_rd1, 0);
        chk("clamp_rd0_cnt", n_rd0, 3);

        setm(16'h0150, 0, 0);
        run_cmd(OP_CLP, 1, 16'h0150, 16'h0150, 16'h0350, 0, 0, 5, -5, 0, 0, 0);
        exp_d = '{5};
        chk_writes("clamp_lo_gt_hi", 16'h0350);

        setm(16'h0160, -7, 0); setm(16'h0161, 9, 0);
        run_cmd(OP_RELU, 2, 16'h0160, 16'h0160, 16'h0360, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{0, 9};
        chk_writes("relu", 16'h0360);

        setm(16'h0170, 3, -4);
        run_cmd(OP_MAX, 1, 16'h0170, 16'h0170, 16'h0370, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{3};
        chk_writes("max", 16'h0370);
        run_cmd(OP_MIN, 1, 16'h0170, 16'h0170, 16'h0370, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{-4};
        chk_writes("min", 16'h0370);

        for (int i = 0; i < 16; i++) begin
            mem0[16'h1000 + 16'(i)] = 8'(i);
            mem1[16'h2000 + 16'(i)] = 8'd1;
        end
        run_cmd(OP_ADD, 16, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 0, 0, 2);
        exp_d.delete();
        for (int i = 0; i < 16; i++) exp_d.push_back(i + 1);
        chk_writes("tput", 16'h3000);
        chk("tput_first_cyc", wq_cyc[0], 3);
        chk("tput_last_cyc", wq_cyc[15], 18);
        chk("tput_done_cyc", done_cyc, 19);
        chk("tput_busy", n_busy, 19);
        chk("tput_rd_addr_bad", rd_bad, 0);
        chk("tput_rd1_cnt", n_rd1, 16);

        run_cmd(OP_ADD, 0, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 0, 0, 0);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_done_cnt", n_done, 1);
        chk("len0_traffic", n_rd0 + n_rd1 + wq_data.size(), 0);
        chk("len0_busy", n_busy, 1);

        for (int i = 0; i < 4; i++) setm(16'h0400 + 16'(i), 1, 2);
        run_cmd(OP_ADD, 4, 16'h0400, 16'h0400, 16'hFFFE, 0, 0, 0, 0, 0, 0, 0);
        exp_d = '{3, 3, 3, 3};
        chk_writes("wrap", 16'hFFFE);

        run_cmd(OP_ADD, 16, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 5, 0, 0);
        exp_d = '{1, 2};
        chk_writes("abort", 16'h3000);
        chk("abort_last_wr_cyc", wq_cyc[wq_cyc.size() - 1], 4);
        chk("abort_done_cnt", n_done, 0);
        chk("abort_busy", n_busy, 5);
        chk("abort_rd0_cnt", n_rd0, 4);
        chk("abort_ready_after", cmd_ready, 1);

        run_cmd(OP_ADD, 16, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0, 0, 0, 6, 0);
        chk("rst_outs", rst_vec, 6'b100000);
        chk("rst_wr_after", wr_after_rst, 0);
        chk("rst_nwr_before", wq_data.size(), 3);
        chk("rst_done_cnt", n_done, 0);
        chk("rst_ready_after", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
